flash_pattern_gen: RTL and testbench
====================================

Name: flash_pattern_gen

Overview:
Downstream consumer of the 640x480 video timing generator. Takes the raw de/hsync/vsync timing stream and produces the RGB pixel stream with the periodic white flash box used for input-lag measurement. Delays the sync signals to stay aligned with the pixels. Emits a one-cycle marker on the first flashed pixel so the measurement timer can start.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
OFF_FRAMES, 59, dark frames per cycle (1..255)
ON_FRAMES, 1, flash frames per cycle (1..255)
BOX_X0, 192, flash box left column
BOX_Y0, 112, flash box top line
BOX_W, 256, flash box width in pixels
BOX_H, 256, flash box height in lines

Ports:
clock  in  1  pixel clock
reset  in  1  synchronous, active-high reset
enable  in  1  flash sequence enable, sampled at frame boundaries
de_in  in  1  data enable from timing generator
hsync_in  in  1  hsync from timing generator
vsync_in  in  1  vsync from timing generator
red  out  8  pixel red
green  out  8  pixel green
blue  out  8  pixel blue
de  out  1  de_in delayed 1 cycle
hsync  out  1  hsync_in delayed 1 cycle
vsync  out  1  vsync_in delayed 1 cycle
flash_start  out  1  one-cycle pulse on first flashed pixel of each flash phase

Behaviour:
- Reset (synchronous, active-high): red/green/blue=0, de=0, hsync=vsync=inactive level (!SYNC_POL), flash_start=0, state=IDLE, x=y=0, frame count=0, sync_seen=0.
- Latency: all outputs registered; exactly 1 cycle from inputs to de/hsync/vsync/rgb/flash_start.
- x counter (11 bit): increments on each cycle with de_in=1 and resets to 0 when de_in=0. Saturates at 2047; never wraps.
- y counter (11 bit): increments on each de_in 1->0 edge and resets to 0 on the vsync_in inactive->active edge.
- Frame boundary (fb) is the vsync_in inactive->active edge. It sets sync_seen=1.
- FSM:
  - IDLE: outputs black. On fb with enable=1 and sync_seen already set (i.e. at the second fb after reset), load count=OFF_FRAMES-1 and go to DARK.
  - DARK: black. On fb: if enable=0 go to IDLE; else if count==0 load ON_FRAMES-1 and go to FLASH; else decrement count.
  - FLASH: box white. On fb: if enable=0 go to IDLE; else if count==0 load OFF_FRAMES-1 and go to DARK; else decrement count.
  - State changes only at fb, so a frame is never split between two states.
- Pixel colour: FLASH && de_in && BOX_X0<=x<BOX_X0+BOX_W && BOX_Y0<=y<BOY_Y0+BOX_H gives rgb=FF/FF/FF. All other cases give 00/00/00, including de_in=0.
- Box bounds are compared at 12-bit width so that sums cannot overflow. Any part of the box beyond H_ACTIVE/V_ACTIVE is simply never hit.
- flash_start: high for exactly 1 cycle, aligned with the first white pixel output (x=BOX_X0, y=BOX_Y0) in the first frame of each FLASH phase. It does not pulse in later frames of a multi-frame FLASH phase.
- enable deasserted mid-frame: the current frame completes unchanged, and the block goes to IDLE at the next fb.
- Reset mid-frame: reset values appear on the next cycle. The block then requires two new fb edges before DARK is entered, so there are no partial flash frames.
- Simultaneous fb and de_in falling edge: the y reset wins.

Decomposition:
- video_pkg: 640x480 timing constants (H_ACTIVE, V_ACTIVE, totals, SYNC_POL), 8-bit colour constants COLOR_WHITE/COLOR_BLACK, and the FSM state enum (IDLE, DARK, FLASH).
- Sub-module pixel_pos_tracker: edge detection on de_in/vsync_in plus the x/y counters. Outputs x, y, fb and sync_seen.

Test Plan:
- Reset held 5 cycles while timing runs -> rgb=0, de=0, hsync=vsync=1; after release, no white pixel before the 2nd vsync falling edge.
- OFF_FRAMES=2, ON_FRAMES=1, enable=1 -> frames go dark, dark, white box, dark, dark, white; flash_start is 1 cycle per white frame, exactly when de=1 at x=192, y=112.
- In a flash frame, probe pixels -> (191,112)=black, (192,112)=white, (447,367)=white, (448,367)=black, (192,368)=black.
- Delay check -> de/hsync/vsync equal the inputs delayed by exactly 1 cycle in all states; rgb=0 whenever de=0.
- enable dropped mid-line of a flash frame -> rest of that frame stays white, next frame is black; re-enable gives OFF_FRAMES dark frames before the next flash.
- ON_FRAMES=3 -> three consecutive white frames but only one flash_start pulse.

Source files
------------

// File: rtl/video_pkg.sv
// Shared 640x480 timing constants, colour levels and the flash FSM state type.
package video_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_TOTAL  = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;
  localparam bit SYNC_POL = 1'b0;

  localparam logic [7:0] COLOR_WHITE = 8'hFF;
  localparam logic [7:0] COLOR_BLACK = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DARK  = 2'd1,
    FLASH = 2'd2
  } flash_state_e;

endpackage

// File: rtl/pixel_pos_tracker.sv
// Recovers the pixel column/line from the raw de/vsync stream and flags frame boundaries.
module pixel_pos_tracker #(
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        de_in,
  input  logic        vsync_in,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        fb,
  output logic        sync_seen
);

  logic de_q;
  logic vs_act_q;
  logic vs_act;
  logic de_fall;

  assign vs_act  = (vsync_in == SYNC_POL);
  assign fb      = vs_act & ~vs_act_q;
  assign de_fall = de_q & ~de_in;

  // vs_act_q resets to "active" so a vsync already asserted at reset release
  // is not mistaken for a fresh frame boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      de_q      <= 1'b0;
      vs_act_q  <= 1'b1;
      x         <= '0;
      y         <= '0;
      sync_seen <= 1'b0;
    end else begin
      de_q     <= de_in;
      vs_act_q <= vs_act;
      if (!de_in)            x <= '0;
      else if (x != 11'h7FF) x <= x + 11'd1;
      if (fb)           y <= '0;
      else if (de_fall) y <= y + 11'd1;
      if (fb) sync_seen <= 1'b1;
    end
  end

endmodule

// File: rtl/flash_pattern_gen.sv
// Turns the raw timing stream into RGB with a periodic white box for input-lag measurement.
module flash_pattern_gen #(
  parameter int H_ACTIVE   = video_pkg::H_ACTIVE,
  parameter int V_ACTIVE   = video_pkg::V_ACTIVE,
  parameter bit SYNC_POL   = video_pkg::SYNC_POL,
  parameter int OFF_FRAMES = 59,
  parameter int ON_FRAMES  = 1,
  parameter int BOX_X0     = 192,
  parameter int BOX_Y0     = 112,
  parameter int BOX_W      = 256,
  parameter int BOX_H      = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic       flash_start
);
  import video_pkg::*;

  localparam logic [7:0]  OFF_LD = 8'(OFF_FRAMES - 1);
  localparam logic [7:0]  ON_LD  = 8'(ON_FRAMES - 1);
  localparam logic [11:0] BX0    = 12'(BOX_X0);
  localparam logic [11:0] BX1    = 12'(BOX_X0 + BOX_W);
  localparam logic [11:0] BY0    = 12'(BOX_Y0);
  localparam logic [11:0] BY1    = 12'(BOX_Y0 + BOX_H);
  localparam logic [11:0] HLIM   = 12'(H_ACTIVE);
  localparam logic [11:0] VLIM   = 12'(V_ACTIVE);

  logic [10:0]  x, y;
  logic         fb, sync_seen;
  flash_state_e state, state_nxt;
  logic [7:0]   count, count_nxt;
  logic         armed, armed_nxt;
  logic         in_box, white, pulse;

  pixel_pos_tracker #(.SYNC_POL(SYNC_POL)) u_pos (
    .clock     (clock),
    .reset     (reset),
    .de_in     (de_in),
    .vsync_in  (vsync_in),
    .x         (x),
    .y         (y),
    .fb        (fb),
    .sync_seen (sync_seen)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      armed <= armed_nxt;
    end
  end

  // Transitions only happen on fb so a frame is never split between states.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    armed_nxt = armed;
    if (pulse) armed_nxt = 1'b0;
    if (fb) begin
      armed_nxt = 1'b0;
      case (state)
        IDLE: if (enable && sync_seen) begin
          state_nxt = DARK;
          count_nxt = OFF_LD;
        end
        DARK: begin
          if (!enable) state_nxt = IDLE;
          else if (count == 8'd0) begin
            state_nxt = FLASH;
            count_nxt = ON_LD;
            armed_nxt = 1'b1;
          end else count_nxt = count - 8'd1;
        end
        FLASH: begin
          if (!enable) state_nxt = IDLE;
          else if (count == 8'd0) begin
            state_nxt = DARK;
            count_nxt = OFF_LD;
          end else count_nxt = count - 8'd1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_box = ({1'b0, x} >= BX0) && ({1'b0, x} < BX1) &&
             ({1'b0, y} >= BY0) && ({1'b0, y} < BY1) &&
             ({1'b0, x} < HLIM) && ({1'b0, y} < VLIM);
    white  = (state == FLASH) && de_in && in_box;
    pulse  = white && armed;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      red         <= COLOR_BLACK;
      green       <= COLOR_BLACK;
      blue        <= COLOR_BLACK;
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      flash_start <= 1'b0;
    end else begin
      red         <= white ? COLOR_WHITE : COLOR_BLACK;
      green       <= white ? COLOR_WHITE : COLOR_BLACK;
      blue        <= white ? COLOR_WHITE : COLOR_BLACK;
      de          <= de_in;
      hsync       <= hsync_in;
      vsync       <= vsync_in;
      flash_start <= pulse;
    end
  end

endmodule

// File: tb/tb_flash_pattern_gen.sv
// Directed bench on a shrunken raster: two instances (ON=1 and ON=3) share one timing stream.
module tb_flash_pattern_gen;

  localparam int HA = 16, HT = 20, HS0 = 17, HS1 = 18;
  localparam int VA = 10, VT = 14, VS0 = 11, VS1 = 12;
  localparam int X0 = 4, Y0 = 3, W = 5, H = 4;
  localparam int NFR = 17;

  logic clock = 1'b0;
  logic reset, enable, de_in, hsync_in, vsync_in;
  logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
  logic a_de, a_hs, a_vs, a_fs, b_de, b_hs, b_vs, b_fs;

  always #5 clock = ~clock;

  flash_pattern_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .SYNC_POL(1'b0), .OFF_FRAMES(2), .ON_FRAMES(1),
    .BOX_X0(X0), .BOX_Y0(Y0), .BOX_W(W), .BOX_H(H)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .de_in(de_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .red(a_r), .green(a_g), .blue(a_b), .de(a_de), .hsync(a_hs),
    .vsync(a_vs), .flash_start(a_fs));

  flash_pattern_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .SYNC_POL(1'b0), .OFF_FRAMES(2), .ON_FRAMES(3),
    .BOX_X0(X0), .BOX_Y0(Y0), .BOX_W(W), .BOX_H(H)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .de_in(de_in), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .red(b_r), .green(b_g), .blue(b_b), .de(b_de), .hsync(b_hs),
    .vsync(b_vs), .flash_start(b_fs));

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hand-derived frame schedule (frame 0 holds reset; fb ends each frame):
  // A (OFF=2,ON=1): white 4,7,10,14. B (OFF=2,ON=3): white 4,5,6,9,10,14,15,16.
  // enable drops in frame 10, returns in frame 11 -> IDLE in 11, dark 12,13.
  logic [NFR-1:0] a_white, b_white, b_pulse;
  initial begin
    a_white = '0; b_white = '0; b_pulse = '0;
    a_white[4] = 1; a_white[7] = 1; a_white[10] = 1; a_white[14] = 1;
    b_white[4] = 1; b_white[5] = 1; b_white[6] = 1; b_white[9] = 1; b_white[10] = 1;
    b_white[14] = 1; b_white[15] = 1; b_white[16] = 1;
    b_pulse[4] = 1; b_pulse[9] = 1; b_pulse[14] = 1;
  end

  int hc, vc, frame, p_hc, p_vc, p_frame;
  logic p_de, p_hs, p_vs;

  task automatic drive();
    de_in    = (hc < HA) && (vc < VA);
    hsync_in = !((hc >= HS0) && (hc <= HS1));
    vsync_in = !((vc >= VS0) && (vc <= VS1));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    p_hc = hc; p_vc = vc; p_frame = frame;
    p_de = de_in; p_hs = hsync_in; p_vs = vsync_in;
    if (hc == HT - 1) begin
      hc = 0;
      if (vc == VT - 1) begin vc = 0; frame++; end
      else vc++;
    end else hc++;
    drive();
  endtask

  int wa, wb, pa, pb, perr, derr;
  logic [23:0] rgb_a, rgb_b;

  task automatic monitor();
    rgb_a = {a_r, a_g, a_b};
    rgb_b = {b_r, b_g, b_b};
    if (a_de !== p_de || a_hs !== p_hs || a_vs !== p_vs) derr++;
    if (b_de !== p_de || b_hs !== p_hs || b_vs !== p_vs) derr++;
    if (!p_de && (rgb_a !== 24'h0 || rgb_b !== 24'h0)) derr++;
    if (rgb_a === 24'hFFFFFF) wa++; else if (rgb_a !== 24'h0) derr++;
    if (rgb_b === 24'hFFFFFF) wb++; else if (rgb_b !== 24'h0) derr++;
    if (a_fs === 1'b1) begin
      pa++;
      if (!(p_hc == X0 && p_vc == Y0 && p_de && rgb_a === 24'hFFFFFF)) perr++;
    end else if (a_fs !== 1'b0) derr++;
    if (b_fs === 1'b1) begin
      pb++;
      if (!(p_hc == X0 && p_vc == Y0 && p_de && rgb_b === 24'hFFFFFF)) perr++;
    end else if (b_fs !== 1'b0) derr++;
    if (a_white[p_frame]) begin
      if (p_hc == X0 - 1 && p_vc == Y0)     check($sformatf("probe_left f%0d", p_frame), rgb_a, 24'h0);
      if (p_hc == X0 && p_vc == Y0)         check($sformatf("probe_tl f%0d", p_frame), rgb_a, 24'hFFFFFF);
      if (p_hc == X0 + W - 1 && p_vc == Y0 + H - 1)
        check($sformatf("probe_br f%0d", p_frame), rgb_a, 24'hFFFFFF);
      if (p_hc == X0 + W && p_vc == Y0 + H - 1)
        check($sformatf("probe_right f%0d", p_frame), rgb_a, 24'h0);
      if (p_hc == X0 && p_vc == Y0 + H)     check($sformatf("probe_below f%0d", p_frame), rgb_a, 24'h0);
    end
    if (p_hc == HT - 1 && p_vc == VT - 1) begin
      check($sformatf("white_a f%0d", p_frame), wa, a_white[p_frame] ? W * H : 0);
      check($sformatf("white_b f%0d", p_frame), wb, b_white[p_frame] ? W * H : 0);
      check($sformatf("pulse_a f%0d", p_frame), pa, a_white[p_frame] ? 1 : 0);
      check($sformatf("pulse_b f%0d", p_frame), pb, b_pulse[p_frame] ? 1 : 0);
      check($sformatf("pulse_pos f%0d", p_frame), perr, 0);
      check($sformatf("delay f%0d", p_frame), derr, 0);
      wa = 0; wb = 0; pa = 0; pb = 0; perr = 0; derr = 0;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1;
    hc = 0; vc = 0; frame = 0;
    wa = 0; wb = 0; pa = 0; pb = 0; perr = 0; derr = 0;
    drive();
    for (int i = 0; i < 5; i++) step();
    check("rst_rgb_a", {a_r, a_g, a_b}, 24'h0);
    check("rst_rgb_b", {b_r, b_g, b_b}, 24'h0);
    check("rst_de", {a_de, b_de}, 2'b00);
    check("rst_sync", {a_hs, a_vs, b_hs, b_vs}, 4'b1111);
    check("rst_fs", {a_fs, b_fs}, 2'b00);
    check("rst_de_in_live", de_in, 1'b1);
    reset = 1'b0;
    while (frame < NFR && tests < 100000) begin
      step();
      if (frame == 10 && vc == 4 && hc == 6) enable = 1'b0;
      if (frame == 11 && vc == 5 && hc == 0) enable = 1'b1;
      monitor();
    end
    check("frames_done", frame, NFR);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
